// File: rtl/quiz_pkg.sv
// +----------------------------------------------------------------------------+
// | quiz_pkg                                                                    |
// | Shared types and constants for the quiz game-flow controller.               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package quiz_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ASK   = 2'd1,
    JUDGE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int               LFSR_W    = 4;
  // x^4 + x^3 + 1: feedback from the two most significant stages
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100;
  localparam logic [1:0]        MAX_ROUND = 2'd3;
  localparam int                MAX_SCORE = 4;

  localparam logic [1:0] ANSWER_KEY [4][4] = '{
    '{2'd1, 2'd0, 2'd3, 2'd2},
    '{2'd2, 2'd3, 2'd0, 2'd1},
    '{2'd3, 2'd2, 2'd1, 2'd0},
    '{2'd0, 2'd2, 2'd1, 2'd3}
  };

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] v);
    return ^(v & LFSR_TAPS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/quiz_lfsr.sv
// +----------------------------------------------------------------------------+
// | quiz_lfsr                                                                   |
// | Free-running 4-bit Fibonacci LFSR; exposes the low two bits as a selector.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module quiz_lfsr
  import quiz_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 4'b1001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [1:0] sel_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  if (SEED == '0) begin : g_seed_chk
    $error("quiz_lfsr: SEED must be non-zero");
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_feedback(lfsr_q)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign sel_o = lfsr_q[1:0];

endmodule

`default_nettype wire

// File: rtl/quiz_sequencer.sv
// +----------------------------------------------------------------------------+
// | quiz_sequencer                                                              |
// | Game-flow controller: issues pattern/round, collects verdicts, keeps score. |
// | Optional per-round timeout enabled by defining QUIZ_TIMEOUT_EN.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module quiz_sequencer
  import quiz_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         SCORE_W        = 3,
  parameter logic [3:0] LFSR_SEED      = 4'b1001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ans_valid,
  input  logic               correct_ans,
  output logic [1:0]         pattern,
  output logic [1:0]         round,
  output logic               ans_ready,
  output logic               result_valid,
  output logic               result_correct,
  output logic               result_timeout,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [1:0]         pattern_q, pattern_d;
  logic [1:0]         round_q, round_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               res_correct_q, res_correct_d;
  logic               res_timeout_q, res_timeout_d;
  logic [1:0]         w_lfsr_sel;
  logic               w_expire;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 20)) begin : g_timeout_chk
    $error("quiz_sequencer: TIMEOUT_CYCLES out of range");
  end
  if (SCORE_W < 3) begin : g_score_chk
    $error("quiz_sequencer: SCORE_W must be at least 3");
  end

  quiz_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (1'b1),
    .sel_o (w_lfsr_sel)
  );

`ifdef QUIZ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside ASK so every ASK entry starts a fresh count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt_q <= '0;
    else if (state_q != ASK) cnt_q <= '0;
    else                     cnt_q <= cnt_q + CNT_W'(1);
  end

  assign w_expire = (state_q == ASK) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = ASK;
      ASK:        if (ans_valid || w_expire) state_d = JUDGE;
      JUDGE:      state_d = (round_q == MAX_ROUND) ? DONE : ASK;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    ans_ready    = (state_q == ASK);
    result_valid = (state_q == JUDGE);
    busy         = (state_q == ASK) || (state_q == JUDGE);
    done         = (state_q == DONE);
  end

  always_comb begin
    pattern_d     = pattern_q;
    round_d       = round_q;
    score_d       = score_q;
    res_correct_d = res_correct_q;
    res_timeout_d = res_timeout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pattern_d = w_lfsr_sel;
          round_d   = 2'd0;
          score_d   = '0;
        end
      end
      ASK: begin
        // A real submit takes priority over an expiring timer
        if (ans_valid) begin
          res_correct_d = correct_ans;
          res_timeout_d = 1'b0;
          if (correct_ans && score_q != SCORE_W'(MAX_SCORE)) score_d = score_q + SCORE_W'(1);
        end else if (w_expire) begin
          res_correct_d = 1'b0;
          res_timeout_d = 1'b1;
        end
      end
      JUDGE: begin
        if (round_q != MAX_ROUND) round_d = round_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q     <= '0;
      round_q       <= '0;
      score_q       <= '0;
      res_correct_q <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      pattern_q     <= pattern_d;
      round_q       <= round_d;
      score_q       <= score_d;
      res_correct_q <= res_correct_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign pattern        = pattern_q;
  assign round          = round_q;
  assign score          = score_q;
  assign result_correct = res_correct_q;
  assign result_timeout = res_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_quiz_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_quiz_sequencer                                                           |
// | Randomized self-checking bench for quiz_sequencer against a game model.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_quiz_sequencer;
  import quiz_pkg::*;

  localparam int         TMO  = 8;
  localparam logic [3:0] SEED = 4'b1001;
`ifdef QUIZ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, ans_valid, correct_ans;
  logic [1:0] pattern, round;
  logic       ans_ready, result_valid, result_correct, result_timeout, busy, done;
  logic [2:0] score;
  logic [1:0] sw;

  int n_vec = 0;
  int n_bad = 0;

  // Game model: phase 0 idle, 1 waiting for answer, 2 showing verdict, 3 over
  bit [3:0] m_lfsr;
  int       m_phase, m_pat, m_rnd, m_score, m_wait;
  bit       m_rc, m_rt;

  always #5 clk = ~clk;

  quiz_sequencer #(
    .TIMEOUT_CYCLES (TMO),
    .SCORE_W        (3),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ans_valid      (ans_valid),
    .correct_ans    (correct_ans),
    .pattern        (pattern),
    .round          (round),
    .ans_ready      (ans_ready),
    .result_valid   (result_valid),
    .result_correct (result_correct),
    .result_timeout (result_timeout),
    .score          (score),
    .busy           (busy),
    .done           (done)
  );

  // Checker stand-in: verdict follows the switches against the model's question
  always_comb correct_ans = (sw == ANSWER_KEY[m_pat][m_rnd]);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [1:0] key();
    return ANSWER_KEY[m_pat][m_rnd];
  endfunction

  task automatic model_step(input bit st, input bit av, input bit ca);
    case (m_phase)
      0, 3: if (st) begin
        m_pat = int'(m_lfsr[1:0]); m_rnd = 0; m_score = 0; m_wait = 0; m_phase = 1;
      end
      1: if (av) begin
        m_rc = ca; m_rt = 0; m_phase = 2;
        m_score = (m_score + int'(ca) > 4) ? 4 : m_score + int'(ca);
      end else if (TO_EN && m_wait == TMO - 1) begin
        m_rc = 0; m_rt = 1; m_phase = 2;
      end else begin
        m_wait++;
      end
      2: if (m_rnd == 3) m_phase = 3;
         else begin m_rnd++; m_wait = 0; m_phase = 1; end
      default: ;
    endcase
    m_lfsr = {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
  endtask

  task automatic check_outputs();
    chk("ans_ready", ans_ready, m_phase == 1);
    chk("result_valid", result_valid, m_phase == 2);
    chk("busy", busy, m_phase == 1 || m_phase == 2);
    chk("done", done, m_phase == 3);
    chk("pattern", pattern, m_pat);
    chk("round", round, m_rnd);
    chk("score", score, m_score);
    chk("result_correct", result_correct, m_rc);
    chk("result_timeout", result_timeout, m_rt);
  endtask

  task automatic cyc(input bit st, input bit av, input bit [1:0] s);
    bit ca;
    start = st; ans_valid = av; sw = s;
    ca = (s == key());
    check_outputs();
    @(posedge clk); #1;
    model_step(st, av, ca);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; ans_valid = 1'b0;
    #1;
    chk("rst_pattern", pattern, 0);        chk("rst_round", round, 0);
    chk("rst_score", score, 0);            chk("rst_ans_ready", ans_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_correct", result_correct, 0);
    chk("rst_result_timeout", result_timeout, 0);
    chk("rst_busy", busy, 0);              chk("rst_done", done, 0);
    chk("rst_lfsr", dut.u_lfsr.lfsr_q, SEED);
    m_lfsr = SEED; m_phase = 0; m_pat = 0; m_rnd = 0; m_score = 0; m_wait = 0;
    m_rc = 0; m_rt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Plays four rounds from an ASK entry; v[3] is the first round's verdict
  task automatic play(input bit [3:0] v);
    for (int r = 0; r < 4; r++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cyc(bit'($urandom_range(0, 1)), 1'b0, 2'($urandom));
      cyc(bit'($urandom_range(0, 1)), 1'b1, v[3-r] ? key() : key() ^ 2'b01);
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 2'($urandom));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && done !== 1'b1; i++) cyc(1'b0, ans_ready, key());
    chk("drain_done", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit [3:0] v;
    bit [1:0] exp_pat;
    int       n;
    rst = 1'b1; start = 1'b0; ans_valid = 1'b0; sw = 2'd0;
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 20 && m_lfsr != 4'b0110; i++)
      cyc(1'b0, bit'($urandom_range(0, 1)), 2'($urandom));
    chk("lfsr_0110", dut.u_lfsr.lfsr_q, 4'b0110);
    cyc(1'b1, 1'b0, 2'd0);
    chk("pattern_from_0110", pattern, 2'b10);

    play(4'b1111);
    chk("all_score", score, 4); chk("all_done", done, 1); chk("all_busy", busy, 0);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'($urandom));
    chk("done_hold_score", score, 4); chk("done_hold_round", round, 3);

    exp_pat = m_lfsr[1:0];
    cyc(1'b1, 1'b0, 2'd0);
    chk("restart_score", score, 0); chk("restart_done", done, 0);
    chk("restart_round", round, 0); chk("restart_pattern", pattern, exp_pat);
    play(4'b1001);
    chk("mixed_score", score, 2); chk("mixed_done", done, 1);

    for (int g = 0; g < 6; g++) begin
      v = 4'($urandom);
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) cyc(1'b0, bit'($urandom_range(0, 1)), 2'($urandom));
      cyc(1'b1, bit'($urandom_range(0, 1)), 2'($urandom));
      play(v);
      chk("rand_score", score, $countones(v));
    end

    // Silent round: timeout build forces a wrong verdict, default build keeps waiting
    cyc(1'b1, 1'b0, 2'd0);
    n = 0;
    while (result_valid !== 1'b1 && n < 40) begin cyc(1'b0, 1'b0, 2'($urandom)); n++; end
`ifdef QUIZ_TIMEOUT_EN
    chk("tmo_latency", n, TMO);
    chk("tmo_flag", result_timeout, 1);
    chk("tmo_correct", result_correct, 0);
`else
    chk("hold_no_result", n, 40);
    chk("hold_ready", ans_ready, 1);
`endif
    chk("silent_score", score, 0);
    drain();

    // Correct submit in the last allowed cycle of the round
    cyc(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < TMO - 1; i++) cyc(1'b0, 1'b0, 2'($urandom));
    cyc(1'b0, 1'b1, key());
    chk("edge_valid", result_valid, 1);
    chk("edge_timeout", result_timeout, 0);
    chk("edge_score", score, 1);
    drain();

    // Reset in round 2 with two points on the board
    cyc(1'b1, 1'b0, 2'd0);
    for (int r = 0; r < 2; r++) begin
      cyc(1'b0, 1'b1, key());
      cyc(1'b0, 1'b0, 2'($urandom));
    end
    chk("pre_rst_round", round, 2); chk("pre_rst_score", score, 2);
    chk("pre_rst_ready", ans_ready, 1);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'($urandom));
    cyc(1'b1, 1'b0, 2'd0);
    play(4'b0110);
    chk("post_rst_score", score, 2);
    cyc(1'b0, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
